// File: rtl/am_demod.sv
// AM envelope detector: full-wave rectify, integrate-and-dump over 2^DECIM_LOG2 accepted samples.
// Define AM_DEMOD_DC_BLOCK_EN to subtract a slowly tracked DC level from each dumped envelope.
module am_demod #(
  parameter int IN_W       = 14,
  parameter int DECIM_LOG2 = 6,
  parameter int DC_SHIFT   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic signed [IN_W-1:0] am_in,
  output logic signed [IN_W-1:0] env_out,
  output logic                   env_valid,
  output logic [DECIM_LOG2-1:0]  win_cnt
);

  // Handshake: in_valid qualifies am_in for one cycle; there is no ready, every
  // valid sample is consumed, and env_valid is a single-cycle strobe with no backpressure.

  localparam int ACC_W = IN_W - 1 + DECIM_LOG2;

  logic [IN_W-1:0]  neg_in;
  logic [IN_W-2:0]  abs_c;
  logic [IN_W-2:0]  abs_r;
  logic             abs_v;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [IN_W-2:0]  dump_val;
  logic             dump_v;

  // Most-negative input has no positive counterpart, so it clips to the largest magnitude.
  always_comb begin
    neg_in = -am_in;
    if (am_in == {1'b1, {(IN_W-1){1'b0}}})
      abs_c = '1;
    else if (am_in[IN_W-1])
      abs_c = neg_in[IN_W-2:0];
    else
      abs_c = am_in[IN_W-2:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      abs_r <= '0;
      abs_v <= 1'b0;
    end else begin
      abs_r <= abs_c;
      abs_v <= in_valid;
    end
  end

  assign sum = acc + {{DECIM_LOG2{1'b0}}, abs_r};

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      win_cnt  <= '0;
      dump_val <= '0;
      dump_v   <= 1'b0;
    end else begin
      dump_v <= 1'b0;
      if (abs_v) begin
        if (win_cnt == '1) begin
          dump_val <= sum[ACC_W-1:DECIM_LOG2];
          acc      <= '0;
          win_cnt  <= '0;
          dump_v   <= 1'b1;
        end else begin
          acc     <= sum;
          win_cnt <= win_cnt + 1'b1;
        end
      end
    end
  end

`ifdef AM_DEMOD_DC_BLOCK_EN
  localparam int DC_W = IN_W + DC_SHIFT;
  localparam logic signed [IN_W+1:0] SAT_HI = (IN_W+2)'(2**(IN_W-1) - 1);
  localparam logic signed [IN_W+1:0] SAT_LO = -SAT_HI - 1;

  logic signed [DC_W-1:0] dc;
  logic signed [DC_W:0]   env_ext;
  logic signed [DC_W:0]   diff;
  logic signed [DC_W:0]   dc_step;
  logic signed [IN_W-1:0] dc_int;
  logic signed [IN_W+1:0] out_full;
  logic signed [IN_W-1:0] out_sat;

  // dc carries DC_SHIFT fractional bits; the output uses the pre-update integer part.
  always_comb begin
    env_ext  = $signed({2'b00, dump_val, {DC_SHIFT{1'b0}}});
    diff     = env_ext - $signed({dc[DC_W-1], dc});
    dc_step  = diff >>> DC_SHIFT;
    dc_int   = dc[DC_W-1:DC_SHIFT];
    out_full = $signed({3'b000, dump_val}) - $signed({{2{dc_int[IN_W-1]}}, dc_int});
    if (out_full > SAT_HI)
      out_sat = SAT_HI[IN_W-1:0];
    else if (out_full < SAT_LO)
      out_sat = SAT_LO[IN_W-1:0];
    else
      out_sat = out_full[IN_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dc        <= '0;
      env_out   <= '0;
      env_valid <= 1'b0;
    end else begin
      env_valid <= dump_v;
      if (dump_v) begin
        env_out <= out_sat;
        dc      <= dc + dc_step[DC_W-1:0];
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      env_out   <= '0;
      env_valid <= 1'b0;
    end else begin
      env_valid <= dump_v;
      if (dump_v)
        env_out <= {1'b0, dump_val};
    end
  end
`endif

endmodule
